// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the MEM-stage load/store unit: FSM state type,
// load/store funct3 encodings and small decode helpers.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size lives in funct3[1:0] for both loads and stores
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3[1:0] == 2'b11) || (f3 == 3'b110);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == SZ_H) && lo[0]) || ((f3[1:0] == SZ_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational byte-enable / store-data lane replication and
// load-data lane extraction with sign or zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte enables and lane-replicated store data for the issuing access
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0000_0000;
        case (st_funct3[1:0])
            SZ_B: begin
                be    = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                be    = 4'b0011 << {st_addr_lo[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            SZ_W: begin
                be    = 4'b1111;
                wdata = st_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'h0000_0000;
            end
        endcase
    end

    // Lane selection for the returned word
    always_comb begin
        byte_s = 8'h00;
        case (ld_addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (ld_addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Sign/zero extension by load type
    always_comb begin
        ld_data = 32'h0000_0000;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   ld_data = {{16{half_s[15]}}, half_s};
            F3_LW:   ld_data = rdata;
            F3_LBU:  ld_data = {24'h00_0000, byte_s};
            F3_LHU:  ld_data = {16'h0000, half_s};
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I MEM-stage load/store unit: one req/gnt/rvalid transaction per access,
// pipeline stall until response, timeout abort. Optional MISALIGN_CHK_EN traps misaligned halves/words.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_M,
    input  logic        kill_M,
    input  logic        mem_rd_M,
    input  logic        mem_wr_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] alu_o_M,
    input  logic [31:0] rs2_data_M,
    output logic        stall_mem,
    output logic [31:0] rd_data_M,
    output logic        mem_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Last REQ/WAIT cycle: the count reaches TIMEOUT_CYC-1 on this edge
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 2);

    lsu_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addr_r, wdata_r, cap_data_r;
    logic [3:0]       be_r;
    logic [2:0]       f3_r;
    logic [1:0]       lo_r;
    logic             we_r, cap_err_r;

    logic             access_s, bad_s, misalign_s, timeout_s;
    logic             cap_load_s, cap_err_s, cnt_clr_s;
    logic [31:0]      cap_data_s, wdata_s, ld_data_s;
    logic [3:0]       be_s;

    assign access_s  = valid_M & (mem_rd_M | mem_wr_M) & ~kill_M;
    assign timeout_s = (cnt_r == TO_LAST);

`ifdef MISALIGN_CHK_EN
    assign misalign_s = f3_misaligned(funct3_M, alu_o_M[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    assign bad_s = f3_illegal(funct3_M) | misalign_s;

    lsu_align u_align (
        .st_funct3  (funct3_M),
        .st_addr_lo (alu_o_M[1:0]),
        .st_data    (rs2_data_M),
        .ld_funct3  (f3_r),
        .ld_addr_lo (lo_r),
        .rdata      (dmem_rdata),
        .be         (be_s),
        .wdata      (wdata_s),
        .ld_data    (ld_data_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Timeout counter: cleared when an access is issued, counts REQ/WAIT cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (cnt_clr_s) begin
            cnt_r <= '0;
        end else if ((state_r == REQ) || (state_r == WAIT)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= '0;
        end
    end

    // Request latches, loaded as the access leaves IDLE so REQ can hold the bus stable
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= 32'h0000_0000;
            lo_r    <= 2'b00;
            be_r    <= 4'b0000;
            wdata_r <= 32'h0000_0000;
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
        end else if ((state_r == IDLE) && access_s) begin
            addr_r  <= {alu_o_M[31:2], 2'b00};
            lo_r    <= alu_o_M[1:0];
            be_r    <= be_s;
            wdata_r <= wdata_s;
            we_r    <= mem_wr_M;
            f3_r    <= funct3_M;
        end
    end

    // Result capture, presented to MEM/WB during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_data_r <= 32'h0000_0000;
            cap_err_r  <= 1'b0;
        end else if (cap_load_s) begin
            cap_data_r <= cap_data_s;
            cap_err_r  <= cap_err_s;
        end
    end

    // Next state, bus outputs and capture control
    always_comb begin
        state_nxt_s = state_r;
        stall_mem   = 1'b0;
        rd_data_M   = 32'h0000_0000;
        mem_err     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = 32'h0000_0000;
        dmem_be     = 4'b0000;
        dmem_wdata  = 32'h0000_0000;
        cap_load_s  = 1'b0;
        cap_data_s  = 32'h0000_0000;
        cap_err_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        if (rst) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (access_s) begin
                        stall_mem = 1'b1;
                        if (bad_s) begin
                            // Trapped without touching the bus
                            state_nxt_s = DONE;
                            cap_load_s  = 1'b1;
                            cap_err_s   = 1'b1;
                        end else begin
                            dmem_req    = 1'b1;
                            dmem_we     = mem_wr_M;
                            dmem_addr   = {alu_o_M[31:2], 2'b00};
                            dmem_be     = be_s;
                            dmem_wdata  = wdata_s;
                            cnt_clr_s   = 1'b1;
                            state_nxt_s = dmem_gnt ? WAIT : REQ;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                REQ: begin
                    stall_mem = 1'b1;
                    if (timeout_s) begin
                        // Request dropped so no grant can be taken on the abort cycle
                        state_nxt_s = DONE;
                        cap_load_s  = 1'b1;
                        cap_err_s   = 1'b1;
                    end else begin
                        dmem_req    = 1'b1;
                        dmem_we     = we_r;
                        dmem_addr   = addr_r;
                        dmem_be     = be_r;
                        dmem_wdata  = wdata_r;
                        state_nxt_s = dmem_gnt ? WAIT : REQ;
                    end
                end
                WAIT: begin
                    stall_mem = 1'b1;
                    if (dmem_rvalid) begin
                        state_nxt_s = DONE;
                        cap_load_s  = 1'b1;
                        cap_data_s  = we_r ? 32'h0000_0000 : ld_data_s;
                        cap_err_s   = dmem_err;
                    end else if (timeout_s) begin
                        state_nxt_s = DONE;
                        cap_load_s  = 1'b1;
                        cap_err_s   = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                DONE: begin
                    rd_data_M   = cap_data_r;
                    mem_err     = cap_err_r;
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with a scripted memory bus.
module tb_mem_stage_lsu;
    import riscv_pkg::*;

    logic        clk, rst, valid_M, kill_M, mem_rd_M, mem_wr_M;
    logic [2:0]  funct3_M;
    logic [31:0] alu_o_M, rs2_data_M;
    logic        stall_mem, mem_err, dmem_req, dmem_we;
    logic [31:0] rd_data_M, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the most recent access
    int          obs_stall, obs_req_cyc;
    logic        obs_stable, obs_done, obs_err, obs_we;
    logic [31:0] obs_rd, obs_addr, obs_wdata;
    logic [3:0]  obs_be;

    mem_stage_lsu #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .valid_M(valid_M), .kill_M(kill_M),
        .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M), .funct3_M(funct3_M),
        .alu_o_M(alu_o_M), .rs2_data_M(rs2_data_M), .stall_mem(stall_mem),
        .rd_data_M(rd_data_M), .mem_err(mem_err), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        valid_M = 1'b0; kill_M = 1'b0; mem_rd_M = 1'b0; mem_wr_M = 1'b0;
        funct3_M = 3'b000; alu_o_M = 32'h0; rs2_data_M = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0; dmem_err = 1'b0;
    endtask

    // Drives one access; gnt in cycle gnt_dly (<0: never), rvalid rsp_dly cycles after gnt (<0: never)
    task automatic do_access(input logic rd, input logic wr, input logic kill, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input int gnt_dly,
                             input int rsp_dly, input logic [31:0] rdata, input logic err);
        valid_M = 1'b1; kill_M = kill; mem_rd_M = rd; mem_wr_M = wr;
        funct3_M = f3; alu_o_M = addr; rs2_data_M = wd;
        obs_stall = 0; obs_req_cyc = 0; obs_stable = 1'b1; obs_done = 1'b0;
        obs_rd = 32'h0; obs_err = 1'b0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_be = 4'h0; obs_we = 1'b0;
        for (int cyc = 0; cyc < 64 && !obs_done; cyc++) begin
            dmem_gnt    = (cyc == gnt_dly);
            dmem_rvalid = (gnt_dly >= 0) && (rsp_dly >= 0) && (cyc == gnt_dly + rsp_dly);
            dmem_rdata  = dmem_rvalid ? rdata : 32'h0;
            dmem_err    = dmem_rvalid ? err : 1'b0;
            @(negedge clk);
            if (dmem_req) begin
                if (obs_req_cyc == 0) begin
                    obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata; obs_we = dmem_we;
                end else if (dmem_addr !== obs_addr || dmem_be !== obs_be ||
                             dmem_wdata !== obs_wdata || dmem_we !== obs_we) begin
                    obs_stable = 1'b0;
                end
                obs_req_cyc++;
            end
            if (stall_mem) begin
                obs_stall++;
            end else begin
                obs_done = 1'b1; obs_rd = rd_data_M; obs_err = mem_err;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        n_checks++;
        if (!obs_done) begin
            n_fail++; $display("FAIL access_bound: stall still high after %0d cycles, required release", obs_stall);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        valid_M = 1'b1; mem_rd_M = 1'b1; funct3_M = F3_LW; alu_o_M = 32'h100; dmem_gnt = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b0 || stall_mem !== 1'b0 || rd_data_M !== 32'h0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: req=%b stall=%b rd=%h err=%b, required all 0",
                               dmem_req, stall_mem, rd_data_M, mem_err);
        end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_mem !== 1'b0 || dmem_req !== 1'b0 || rd_data_M !== 32'h0) begin
            n_fail++; $display("FAIL idle_stray_rvalid: stall=%b req=%b rd=%h, required 0/0/0",
                               stall_mem, dmem_req, rd_data_M);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw_min_latency();
        do_access(1'b1, 1'b0, 1'b0, F3_LW, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0);
        n_checks++;
        if (obs_stall != 2) begin n_fail++; $display("FAIL lw_stall: got %0d cycles, required 2", obs_stall); end
        n_checks++;
        if (obs_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h, required deadbeef", obs_rd); end
        n_checks++;
        if (obs_err !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b, required 0", obs_err); end
        n_checks++;
        if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0) begin
            n_fail++; $display("FAIL lw_bus: addr=%h be=%h we=%b, required 00000100/f/0", obs_addr, obs_be, obs_we);
        end
    endtask

    task automatic test_byte_half_loads();
        do_access(1'b1, 1'b0, 1'b0, F3_LB, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF, 1'b0);
        n_checks++;
        if (obs_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b, required 1000", obs_be); end
        n_checks++;
        if (obs_rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h, required ffffff80", obs_rd); end
        do_access(1'b1, 1'b0, 1'b0, F3_LBU, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF, 1'b0);
        n_checks++;
        if (obs_rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h, required 00000080", obs_rd); end
        do_access(1'b1, 1'b0, 1'b0, F3_LH, 32'h102, 32'h0, 0, 1, 32'h8001_7FFF, 1'b0);
        n_checks++;
        if (obs_rd !== 32'hFFFF_8001 || obs_be !== 4'b1100) begin
            n_fail++; $display("FAIL lh_rdata: rd=%h be=%b, required ffff8001/1100", obs_rd, obs_be);
        end
        do_access(1'b1, 1'b0, 1'b0, F3_LHU, 32'h100, 32'h0, 0, 1, 32'h8001_7FFF, 1'b0);
        n_checks++;
        if (obs_rd !== 32'h0000_7FFF || obs_be !== 4'b0011) begin
            n_fail++; $display("FAIL lhu_rdata: rd=%h be=%b, required 00007fff/0011", obs_rd, obs_be);
        end
        do_access(1'b1, 1'b0, 1'b0, F3_LBU, 32'h201, 32'h0, 0, 1, 32'h1234_5678, 1'b0);
        n_checks++;
        if (obs_rd !== 32'h0000_0056 || obs_be !== 4'b0010) begin
            n_fail++; $display("FAIL lbu_lane1: rd=%h be=%b, required 00000056/0010", obs_rd, obs_be);
        end
    endtask

    task automatic test_stores();
        do_access(1'b0, 1'b1, 1'b0, 3'b001, 32'h102, 32'h1234_ABCD, 0, 1, 32'hFFFF_FFFF, 1'b0);
        n_checks++;
        if (obs_we !== 1'b1 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_addr !== 32'h100) begin
            n_fail++; $display("FAIL sh_bus: we=%b be=%b wdata=%h addr=%h, required 1/1100/abcdabcd/00000100",
                               obs_we, obs_be, obs_wdata, obs_addr);
        end
        n_checks++;
        if (obs_rd !== 32'h0 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL sh_result: rd=%h err=%b, required 0/0", obs_rd, obs_err);
        end
        do_access(1'b0, 1'b1, 1'b0, 3'b000, 32'h101, 32'h0000_00A5, 0, 1, 32'h0, 1'b0);
        n_checks++;
        if (obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL sb_bus: be=%b wdata=%h, required 0010/a5a5a5a5", obs_be, obs_wdata);
        end
        do_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'hCAFE_1234, 0, 1, 32'h0, 1'b0);
        n_checks++;
        if (obs_be !== 4'hF || obs_wdata !== 32'hCAFE_1234 || obs_stall != 2) begin
            n_fail++; $display("FAIL sw_bus: be=%h wdata=%h stall=%0d, required f/cafe1234/2", obs_be, obs_wdata, obs_stall);
        end
    endtask

    task automatic test_gnt_delay();
        do_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h204, 32'h5A5A_0F0F, 3, 1, 32'h0, 1'b0);
        n_checks++;
        if (obs_stall != 5) begin n_fail++; $display("FAIL gnt_delay_stall: got %0d, required 5", obs_stall); end
        n_checks++;
        if (obs_req_cyc != 4) begin n_fail++; $display("FAIL gnt_delay_req: got %0d req cycles, required 4", obs_req_cyc); end
        n_checks++;
        if (obs_stable !== 1'b1 || obs_addr !== 32'h204 || obs_wdata !== 32'h5A5A_0F0F) begin
            n_fail++; $display("FAIL gnt_delay_stable: stable=%b addr=%h wdata=%h, required 1/00000204/5a5a0f0f",
                               obs_stable, obs_addr, obs_wdata);
        end
    endtask

    task automatic test_bus_error();
        do_access(1'b1, 1'b0, 1'b0, F3_LW, 32'h300, 32'h0, 0, 2, 32'h1122_3344, 1'b1);
        n_checks++;
        if (obs_err !== 1'b1 || obs_stall != 3 || obs_rd !== 32'h1122_3344) begin
            n_fail++; $display("FAIL bus_err: err=%b stall=%0d rd=%h, required 1/3/11223344", obs_err, obs_stall, obs_rd);
        end
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 1'b0, F3_LW, 32'h400, 32'h0, 0, -1, 32'h0, 1'b0);
        n_checks++;
        if (obs_stall != 16) begin n_fail++; $display("FAIL timeout_stall: got %0d, required 16", obs_stall); end
        n_checks++;
        if (obs_err !== 1'b1 || obs_rd !== 32'h0) begin
            n_fail++; $display("FAIL timeout_result: err=%b rd=%h, required 1/0", obs_err, obs_rd);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
                n_fail++; $display("FAIL timeout_after: req=%b stall=%b, required 0/0", dmem_req, stall_mem);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_and_kill();
        do_access(1'b1, 1'b0, 1'b0, 3'b011, 32'h500, 32'h0, -1, -1, 32'h0, 1'b0);
        n_checks++;
        if (obs_stall != 1 || obs_req_cyc != 0 || obs_err !== 1'b1 || obs_rd !== 32'h0) begin
            n_fail++; $display("FAIL illegal_f3: stall=%0d req=%0d err=%b rd=%h, required 1/0/1/0",
                               obs_stall, obs_req_cyc, obs_err, obs_rd);
        end
        do_access(1'b1, 1'b0, 1'b1, F3_LW, 32'h600, 32'h0, 0, 1, 32'hFFFF_FFFF, 1'b0);
        n_checks++;
        if (obs_stall != 0 || obs_req_cyc != 0 || obs_rd !== 32'h0) begin
            n_fail++; $display("FAIL kill: stall=%0d req=%0d rd=%h, required 0/0/0", obs_stall, obs_req_cyc, obs_rd);
        end
    endtask

    task automatic test_reset_mid();
        valid_M = 1'b1; mem_rd_M = 1'b1; funct3_M = F3_LW; alu_o_M = 32'h700; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        n_checks++;
        if (stall_mem !== 1'b0 || dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_release: stall=%b req=%b, required 0/0", stall_mem, dmem_req);
        end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if (stall_mem !== 1'b0 || dmem_req !== 1'b0 || rd_data_M !== 32'h0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_idle: stall=%b req=%b rd=%h err=%b, required 0/0/0/0",
                               stall_mem, dmem_req, rd_data_M, mem_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_CHK_EN
        do_access(1'b1, 1'b0, 1'b0, F3_LW, 32'h101, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0);
        n_checks++;
        if (obs_stall != 1 || obs_req_cyc != 0 || obs_err !== 1'b1 || obs_rd !== 32'h0) begin
            n_fail++; $display("FAIL misalign_trap: stall=%0d req=%0d err=%b rd=%h, required 1/0/1/0",
                               obs_stall, obs_req_cyc, obs_err, obs_rd);
        end
`else
        do_access(1'b1, 1'b0, 1'b0, F3_LW, 32'h101, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0);
        n_checks++;
        if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_rd !== 32'hCAFE_F00D || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL misalign_pass: addr=%h be=%h rd=%h err=%b, required 00000100/f/cafef00d/0",
                               obs_addr, obs_be, obs_rd, obs_err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h800, 32'h55AA_55AA, 0, 1, 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 1'b0, F3_LH, 32'h806, 32'h0, 1, 2, 32'h9ABC_0000, 1'b0);
        n_checks++;
        if (obs_stall != 4 || obs_rd !== 32'hFFFF_9ABC || obs_addr !== 32'h804) begin
            n_fail++; $display("FAIL back_to_back: stall=%0d rd=%h addr=%h, required 4/ffff9abc/00000804",
                               obs_stall, obs_rd, obs_addr);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_lw_min_latency();
        test_byte_half_loads();
        test_stores();
        test_gnt_delay();
        test_bus_error();
        test_timeout();
        test_illegal_and_kill();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
